// File: rtl/gon_pkg.sv
// ----------------------------------------------------------------------------
// gon_pkg
//   Shared GON bus parameters used by every block that sits on the GON
//   X-bus. Blocks take their bus widths and default buffer depth from here
//   instead of redefining them locally.
// ----------------------------------------------------------------------------
package gon_pkg;

  // Width of a word on the GON value bus.
  localparam int GON_VALUE_LEN = 32;

  // Width of the multicast tag/ID field on the GON bus.
  localparam int GON_ID_LEN    = 4;

  // Default entry count of a PE input buffer (power of two, >= 2).
  localparam int GON_BUF_DEPTH = 4;

endpackage : gon_pkg

// File: rtl/gon_fifo_mem.sv
// ----------------------------------------------------------------------------
// gon_fifo_mem
//   DEPTH x VALUE_LEN register array. It has one synchronous write port and
//   one combinational read port, so a word written at an edge can be read in
//   the following cycle with no added stage.
//
// Ports
//   clk        in   system clock
//   wr_en_i    in   write strobe
//   wr_addr_i  in   write address
//   wr_data_i  in   write data
//   rd_addr_i  in   read address
//   rd_data_o  out  data at rd_addr_i (combinational)
// ----------------------------------------------------------------------------
module gon_fifo_mem
  import gon_pkg::*;
#(
  parameter int VALUE_LEN = GON_VALUE_LEN,
  parameter int DEPTH     = GON_BUF_DEPTH,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [ADDR_W-1:0]    wr_addr_i,
  input  logic [VALUE_LEN-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]    rd_addr_i,
  output logic [VALUE_LEN-1:0] rd_data_o
);

  logic [VALUE_LEN-1:0] mem_q [DEPTH];

  // NOTE: the storage array has no reset. Stale entries are never visible,
  // because the pointers and count gate every read, and leaving the array
  // unreset keeps it a plain register file instead of DEPTH*VALUE_LEN
  // reset flops.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule : gon_fifo_mem

// File: rtl/gon_pe_input_buffer.sv
// ----------------------------------------------------------------------------
// gon_pe_input_buffer
//   Receive-side FWFT buffer that sits behind a GON X-bus multicast
//   controller. There is one instance per PE input port. The controller
//   writes a word with gon_enable, and this block advertises free space back
//   with gon_ready. The PE pops the head word with a valid/ready handshake.
//   A write attempted while the buffer is full is dropped and sets a sticky
//   overflow flag.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous reset, active-low
//   flush       in   synchronous drain; clears pointers, count, overflow
//   gon_enable  in   write strobe from the controller
//   gon_value   in   write data from the controller
//   gon_ready   out  space available (registered state and rst only)
//   pe_valid    out  head entry valid
//   pe_ready    in   PE consumes the head entry
//   pe_data     out  head entry, 0 when empty
//   count       out  occupancy, 0..DEPTH
//   overflow    out  sticky: a write was attempted while full
// ----------------------------------------------------------------------------
module gon_pe_input_buffer
  import gon_pkg::*;
#(
  parameter int VALUE_LEN = GON_VALUE_LEN,
  parameter int DEPTH     = GON_BUF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   gon_enable,
  input  logic [VALUE_LEN-1:0]   gon_value,
  output logic                   gon_ready,
  output logic                   pe_valid,
  input  logic                   pe_ready,
  output logic [VALUE_LEN-1:0]   pe_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int ADDR    = $clog2(DEPTH);
  localparam int CNT_LEN = ADDR + 1;

  logic [ADDR-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_LEN-1:0]   count_q,  count_d;
  logic                 overflow_q, overflow_d;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic [VALUE_LEN-1:0] rd_data;

  // Handshake terms come from registered state only. gon_ready has no path
  // from gon_enable or pe_ready.
  assign full      = (count_q == CNT_LEN'(DEPTH));
  assign gon_ready = rst & ~full;
  assign pe_valid  = (count_q != '0);
  assign push      = gon_enable & gon_ready;
  assign pop       = pe_valid & pe_ready;

  // NOTE: every signal driven in this block gets a default first. A path
  // that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (flush) begin
      // Flush wins over a same-cycle push or pop. The push is discarded
      // and cannot set overflow.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_LEN'(1);
        2'b01:   count_d = count_q - CNT_LEN'(1);
        default: count_d = count_q;
      endcase
      // A write attempted while full is dropped. A pop in the same cycle
      // still frees one slot.
      if (gon_enable && full) overflow_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples its pre-edge value, whatever order the blocks evaluate in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  gon_fifo_mem #(
    .VALUE_LEN (VALUE_LEN),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push & ~flush),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (gon_value),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign pe_data  = pe_valid ? rd_data : '0;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule : gon_pe_input_buffer
